// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer between the PC register (setPc),
// the instruction memory and the instruction consumer.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_reset      asynchronous active-low reset
//   i_run        fetch enable; 0 parks the block in IDLE once the current transaction is done
//   i_pcOut      current PC from setPc
//   o_incPc      one-cycle request to increment the PC
//   o_loadPc     one-cycle request to load o_pcIn into the PC
//   o_pcIn       PC load value, 0 whenever o_loadPc is 0
//   o_memReq     instruction memory read request
//   o_memAddr    read address, captured from i_pcOut when the request starts
//   i_memAck     read complete, i_memData valid this cycle
//   i_memData    instruction word from memory
//   o_instValid  instruction available to the consumer
//   o_instr      fetched instruction
//   o_instPc     address of o_instr
//   i_instReady  consumer accepts the instruction while o_instValid is 1
//   i_jump       one-cycle redirect request
//   i_jumpAddr   redirect target, sampled with i_jump
module fetch_ctrl #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic [ADDR_W-1:0] i_pcOut,
    output logic              o_incPc,
    output logic              o_loadPc,
    output logic [ADDR_W-1:0] o_pcIn,
    output logic              o_memReq,
    output logic [ADDR_W-1:0] o_memAddr,
    input  logic              i_memAck,
    input  logic [DATA_W-1:0] i_memData,
    output logic              o_instValid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_instPc,
    input  logic              i_instReady,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jumpAddr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        UPDATE = 2'd3
    } stateT;

    stateT             state;
    stateT             stateNxt;
    // UPDATE spans the inc/load pulse cycle plus one cycle in which the new
    // i_pcOut is visible; settled marks the second of the two.
    logic              settled;
    logic              settledNxt;
    // A jump seen while a read is outstanding is parked here until the ack.
    logic              flush;
    logic              flushNxt;
    logic [ADDR_W-1:0] flushAddr;
    logic [ADDR_W-1:0] flushAddrNxt;

    logic              incPcNxt;
    logic              loadPcNxt;
    logic [ADDR_W-1:0] pcInNxt;
    logic              memReqNxt;
    logic [ADDR_W-1:0] memAddrNxt;
    logic              instValidNxt;
    logic [DATA_W-1:0] instrNxt;
    logic [ADDR_W-1:0] instPcNxt;

    // State register and flush bookkeeping
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            settled   <= 1'b0;
            flush     <= 1'b0;
            flushAddr <= '0;
        end else begin
            state     <= stateNxt;
            settled   <= settledNxt;
            flush     <= flushNxt;
            flushAddr <= flushAddrNxt;
        end
    end

    // Next-state logic; a jump always wins over run/ready
    always_comb begin
        stateNxt     = state;
        settledNxt   = settled;
        flushNxt     = flush;
        flushAddrNxt = flushAddr;
        case (state)
            IDLE: begin
                if (i_jump) begin
                    stateNxt   = UPDATE;
                    settledNxt = 1'b0;
                end else if (i_run) begin
                    stateNxt = FETCH;
                end
            end
            FETCH: begin
                if (i_memAck) begin
                    stateNxt   = (flush || i_jump) ? UPDATE : HOLD;
                    settledNxt = 1'b0;
                    flushNxt   = 1'b0;
                end else if (i_jump) begin
                    flushNxt     = 1'b1;
                    flushAddrNxt = i_jumpAddr;
                end
            end
            HOLD: begin
                if (i_jump || i_instReady) begin
                    stateNxt   = UPDATE;
                    settledNxt = 1'b0;
                end
            end
            UPDATE: begin
                if (i_jump) begin
                    settledNxt = 1'b0;
                end else if (!settled) begin
                    settledNxt = 1'b1;
                end else begin
                    stateNxt = i_run ? FETCH : IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    // Output logic, computed one cycle ahead and registered below
    always_comb begin
        incPcNxt     = 1'b0;
        loadPcNxt    = 1'b0;
        pcInNxt      = '0;
        memAddrNxt   = o_memAddr;
        instrNxt     = o_instr;
        instPcNxt    = o_instPc;
        memReqNxt    = (stateNxt == FETCH);
        instValidNxt = (stateNxt == HOLD);
        case (state)
            IDLE: begin
                if (i_jump) begin
                    loadPcNxt = 1'b1;
                    pcInNxt   = i_jumpAddr;
                end else if (i_run) begin
                    memAddrNxt = i_pcOut;
                end
            end
            FETCH: begin
                if (i_memAck) begin
                    // Acked data of a redirected fetch is dropped; newest target wins
                    if (i_jump) begin
                        loadPcNxt = 1'b1;
                        pcInNxt   = i_jumpAddr;
                    end else if (flush) begin
                        loadPcNxt = 1'b1;
                        pcInNxt   = flushAddr;
                    end else begin
                        instrNxt  = i_memData;
                        instPcNxt = o_memAddr;
                    end
                end
            end
            HOLD: begin
                if (i_jump) begin
                    loadPcNxt = 1'b1;
                    pcInNxt   = i_jumpAddr;
                end else if (i_instReady) begin
                    incPcNxt = 1'b1;
                end
            end
            UPDATE: begin
                if (i_jump) begin
                    loadPcNxt = 1'b1;
                    pcInNxt   = i_jumpAddr;
                end else if (settled && i_run) begin
                    memAddrNxt = i_pcOut;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_incPc     <= 1'b0;
            o_loadPc    <= 1'b0;
            o_pcIn      <= '0;
            o_memReq    <= 1'b0;
            o_memAddr   <= '0;
            o_instValid <= 1'b0;
            o_instr     <= '0;
            o_instPc    <= '0;
        end else begin
            o_incPc     <= incPcNxt;
            o_loadPc    <= loadPcNxt;
            o_pcIn      <= pcInNxt;
            o_memReq    <= memReqNxt;
            o_memAddr   <= memAddrNxt;
            o_instValid <= instValidNxt;
            o_instr     <= instrNxt;
            o_instPc    <= instPcNxt;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic for fetch_ctrl,
// checked against a transaction-level model of the instruction stream
// (architectural PC, pending redirect, memory contents) and a simple setPc.
module tb_fetch_ctrl;

    logic        clk;
    logic        rstN;
    logic        iRun;
    logic [7:0]  pc;
    logic        o_incPc;
    logic        o_loadPc;
    logic [7:0]  o_pcIn;
    logic        o_memReq;
    logic [7:0]  o_memAddr;
    logic        iMemAck;
    logic [15:0] iMemData;
    logic        o_instValid;
    logic [15:0] o_instr;
    logic [7:0]  o_instPc;
    logic        iInstReady;
    logic        iJump;
    logic [7:0]  iJumpAddr;

    fetch_ctrl #(.ADDR_W(8), .DATA_W(16)) dut (
        .i_clk       (clk),
        .i_reset     (rstN),
        .i_run       (iRun),
        .i_pcOut     (pc),
        .o_incPc     (o_incPc),
        .o_loadPc    (o_loadPc),
        .o_pcIn      (o_pcIn),
        .o_memReq    (o_memReq),
        .o_memAddr   (o_memAddr),
        .i_memAck    (iMemAck),
        .i_memData   (iMemData),
        .o_instValid (o_instValid),
        .o_instr     (o_instr),
        .o_instPc    (o_instPc),
        .i_instReady (iInstReady),
        .i_jump      (iJump),
        .i_jumpAddr  (iJumpAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // setPc model: load beats increment, 8-bit wrap is natural
    logic       pcSetReq;
    logic [7:0] pcSetVal;
    always @(posedge clk) begin
        if (pcSetReq)      pc <= pcSetVal;
        else if (o_loadPc) pc <= o_pcIn;
        else if (o_incPc)  pc <= pc + 8'd1;
    end

    logic [15:0] mem [256];
    logic [7:0]  expPc;      // address the next delivered instruction must have
    logic        pendFlush;  // redirect waiting for the outstanding ack
    logic [7:0]  pendAddr;
    int          tests = 0;
    int          fails = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic forcePc(input logic [7:0] v);
        pcSetReq = 1'b1;
        pcSetVal = v;
        expPc    = v;
    endtask

    // One clock of stimulus; predicts the next cycle from the protocol rules and checks it
    task automatic step(input logic run, input logic rdy, input logic jmp,
                        input logic [7:0] ja, input logic ack);
        logic       ackEff, nInc, nLoad, nValid, prevReq;
        logic [7:0] nPcIn, prevAddr;
        ackEff   = ack && o_memReq;
        prevReq  = o_memReq;
        prevAddr = o_memAddr;
        nInc     = o_instValid && rdy && !jmp;
        nLoad    = 1'b0;
        nPcIn    = 8'h00;
        if (jmp && !(o_memReq && !ackEff)) begin
            nLoad = 1'b1;
            nPcIn = ja;
        end else if (ackEff && pendFlush) begin
            nLoad = 1'b1;
            nPcIn = pendAddr;
        end
        nValid = (ackEff && !jmp && !pendFlush) || (o_instValid && !rdy && !jmp);
        if (o_memReq && !ackEff && jmp) begin
            pendFlush = 1'b1;
            pendAddr  = ja;
        end
        if (ackEff) pendFlush = 1'b0;
        if (jmp) expPc = ja;
        else if (o_instValid && rdy) expPc = expPc + 8'd1;

        iRun       = run;
        iInstReady = rdy;
        iJump      = jmp;
        iJumpAddr  = ja;
        iMemAck    = ackEff;
        iMemData   = ackEff ? mem[o_memAddr] : 16'($urandom);
        @(negedge clk);
        pcSetReq = 1'b0;
        iJump    = 1'b0;
        iMemAck  = 1'b0;

        checkEq("incPc", 32'(o_incPc), 32'(nInc));
        checkEq("loadPc", 32'(o_loadPc), 32'(nLoad));
        checkEq("pcIn", 32'(o_pcIn), 32'(nPcIn));
        checkEq("instValid", 32'(o_instValid), 32'(nValid));
        if (nValid) begin
            checkEq("instPc", 32'(o_instPc), 32'(expPc));
            checkEq("instr", 32'(o_instr), 32'(mem[expPc]));
        end
        if (prevReq) checkEq("memReqHeld", 32'(o_memReq), 32'(!ackEff));
        if (prevReq && o_memReq) checkEq("memAddrStable", 32'(o_memAddr), 32'(prevAddr));
        if (!prevReq && o_memReq) checkEq("memAddrStart", 32'(o_memAddr), 32'(expPc));
    endtask

    task automatic stepUntilReq(input string tag);
        int n = 0;
        while (!o_memReq && n < 20) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            n++;
        end
        checkEq(tag, 32'(o_memReq), 32'd1);
    endtask

    task automatic stepUntilValid(input string tag);
        int n = 0;
        while (!o_instValid && n < 20) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            n++;
        end
        checkEq(tag, 32'(o_instValid), 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, "_memReq"}, 32'(o_memReq), 32'd0);
        checkEq({tag, "_memAddr"}, 32'(o_memAddr), 32'd0);
        checkEq({tag, "_instValid"}, 32'(o_instValid), 32'd0);
        checkEq({tag, "_incPc"}, 32'(o_incPc), 32'd0);
        checkEq({tag, "_loadPc"}, 32'(o_loadPc), 32'd0);
        checkEq({tag, "_instr"}, 32'(o_instr), 32'd0);
    endtask

    initial begin
        int   ackWait;
        logic lastReq;
        logic doAck;

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0]     = 16'h1234;
        rstN       = 1'b0;
        iRun       = 1'b0;
        iMemAck    = 1'b0;
        iMemData   = 16'h0000;
        iInstReady = 1'b0;
        iJump      = 1'b0;
        iJumpAddr  = 8'h00;
        pendFlush  = 1'b0;
        pendAddr   = 8'h00;
        forcePc(8'h00);
        repeat (3) @(negedge clk);
        pcSetReq = 1'b0;
        checkAllZero("reset");
        rstN = 1'b1;

        // Basic fetch: request one cycle after IDLE, ack two cycles later
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkEq("firstReq", 32'(o_memReq), 32'd1);
        checkEq("firstAddr", 32'(o_memAddr), 32'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkEq("basicInstr", 32'(o_instr), 32'h1234);
        checkEq("basicInstPc", 32'(o_instPc), 32'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        checkEq("basicIncPc", 32'(o_incPc), 32'd1);
        stepUntilReq("basicNextReq");
        checkEq("basicNextAddr", 32'(o_memAddr), 32'h01);

        // Consumer stall: instruction held unchanged, no increment
        stepUntilValid("stallValid");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            checkEq("stallInstPc", 32'(o_instPc), 32'h01);
            checkEq("stallNoInc", 32'(o_incPc), 32'd0);
        end
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        checkEq("stallIncPc", 32'(o_incPc), 32'd1);

        // Redirect during an outstanding read; acked word must be dropped
        stepUntilReq("flushReq");
        mem[o_memAddr] = 16'hBEEF;
        step(1'b1, 1'b0, 1'b1, 8'h40, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checkEq("flushLoadPc", 32'(o_loadPc), 32'd1);
        checkEq("flushPcIn", 32'(o_pcIn), 32'h40);
        checkEq("flushNoValid", 32'(o_instValid), 32'd0);
        stepUntilReq("flushNextReq");
        checkEq("flushNextAddr", 32'(o_memAddr), 32'h40);

        // Jump coincident with ready: load only
        stepUntilValid("jumpReadyValid");
        step(1'b1, 1'b1, 1'b1, 8'h80, 1'b0);
        checkEq("jumpReadyLoad", 32'(o_loadPc), 32'd1);
        checkEq("jumpReadyPcIn", 32'(o_pcIn), 32'h80);
        checkEq("jumpReadyNoInc", 32'(o_incPc), 32'd0);

        // PC wrap: fetch 0xFF, then 0x00
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        forcePc(8'hFF);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        stepUntilReq("wrapReq");
        checkEq("wrapAddr", 32'(o_memAddr), 32'hFF);
        stepUntilValid("wrapValid");
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        checkEq("wrapIncPc", 32'(o_incPc), 32'd1);
        stepUntilReq("wrapNextReq");
        checkEq("wrapNextAddr", 32'(o_memAddr), 32'h00);

        // Reset mid-fetch: request drops at once, late ack ignored
        #2 rstN = 1'b0;
        #1 checkEq("rstReqDrop", 32'(o_memReq), 32'd0);
        forcePc(8'h33);
        pendFlush = 1'b0;
        @(negedge clk);
        pcSetReq = 1'b0;
        @(negedge clk);
        checkAllZero("midReset");
        rstN     = 1'b1;
        iRun     = 1'b0;
        iMemAck  = 1'b1;
        iMemData = 16'hBEEF;
        @(negedge clk);
        iMemAck = 1'b0;
        checkEq("lateAckValid", 32'(o_instValid), 32'd0);
        checkEq("lateAckInstr", 32'(o_instr), 32'd0);
        checkEq("lateAckReq", 32'(o_memReq), 32'd0);
        stepUntilReq("restartReq");
        checkEq("restartAddr", 32'(o_memAddr), 32'h33);

        // Randomized traffic
        ackWait = 0;
        lastReq = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (o_memReq && !lastReq) ackWait = int'($urandom_range(0, 3));
            lastReq = o_memReq;
            doAck   = o_memReq && (ackWait == 0);
            if (o_memReq && ackWait != 0) ackWait--;
            step($urandom_range(0, 99) < 92, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 6, 8'($urandom), doAck);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
